// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator call-register slice: floor count default,
// service direction encoding, floor index type and scan FSM state codes.
package elevator_pkg;

  localparam int FLOORS_DEFAULT = 10;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  typedef logic [$clog2(FLOORS_DEFAULT)-1:0] floor_t;

  typedef logic [1:0] scan_state_t;
  localparam scan_state_t S_IDLE = 2'd0;
  localparam scan_state_t S_SCAN = 2'd1;
  localparam scan_state_t S_DONE = 2'd2;

endpackage

// File: rtl/call_button_filter.sv
// Per-vector button front end: optional debounce (CALL_DEBOUNCE_EN) followed by
// rising-edge detection, producing a one-cycle press pulse per bit.
module call_button_filter #(
  parameter int N               = 10,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] btn_in,
  output logic [N-1:0] press_pulse
);

`ifdef CALL_DEBOUNCE_EN
  localparam int             DBW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0]   stable_q, stable_d;
  logic [N-1:0]   pulse_q, pulse_d;
  logic [DBW-1:0] cnt_q [N];
  logic [DBW-1:0] cnt_d [N];

  // A bit flips its stable value only after DEBOUNCE_CYCLES disagreeing samples.
  always_comb begin
    stable_d = stable_q;
    pulse_d  = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (btn_in[i] != stable_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          stable_d[i] = btn_in[i];
          pulse_d[i]  = btn_in[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DBW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      stable_q <= '0;
      pulse_q  <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign press_pulse = pulse_q;
`else
  logic [N-1:0] btn_q;

  // Previous-cycle copy of the (already synchronous) buttons for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_q <= '0;
    end else begin
      btn_q <= btn_in;
    end
  end

  assign press_pulse = btn_in & ~btn_q;
`endif

endmodule

// File: rtl/elevator_call_register.sv
// Elevator request front end: latches button presses, clears served requests and
// republishes above/below summaries via a one-floor-per-cycle scan. Macro: CALL_DEBOUNCE_EN.
module elevator_call_register
  import elevator_pkg::*;
#(
  parameter int FLOORS          = FLOORS_DEFAULT,
  parameter int FW              = $clog2(FLOORS),
  parameter int CW              = $clog2(FLOORS + 1),
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              off_btn,
  input  logic [FW-1:0]     position,
  input  logic [FLOORS-1:0] hall_up_btn,
  input  logic [FLOORS-1:0] hall_dn_btn,
  input  logic [FLOORS-1:0] car_btn,
  input  logic              serve_valid,
  input  logic [FW-1:0]     serve_floor,
  input  logic              serve_dir,
  output logic              serve_ack,
  output logic [FLOORS-1:0] pressed_up,
  output logic [FLOORS-1:0] pressed_dn,
  output logic [FLOORS-1:0] destination,
  output logic [CW-1:0]     count_up,
  output logic [CW-1:0]     count_down,
  output logic [FW-1:0]     nearest_up,
  output logic [FW-1:0]     nearest_down,
  output logic              up_found,
  output logic              down_found,
  output logic              summary_valid
);

  // Top floor has no up button and ground floor has no down button.
  localparam logic [FLOORS-1:0] UP_MASK  = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DN_MASK  = {{(FLOORS-1){1'b1}}, 1'b0};
  localparam logic [FW-1:0]     LAST_IDX = FW'(FLOORS - 1);

  logic [FLOORS-1:0] up_pulse_s, dn_pulse_s, car_pulse_s;
  logic [FLOORS-1:0] clr_up_s, clr_dn_s, clr_dest_s;
  logic [FLOORS-1:0] pressed_up_q, pressed_up_d, pressed_dn_q, pressed_dn_d;
  logic [FLOORS-1:0] destination_q, destination_d, snap_req_q, snap_req_d;
  logic              serve_ack_q, serve_ack_d, dirty_q, dirty_d, dirty_set_s, dirty_clr_s;
  logic [FW-1:0]     position_q, snap_pos_q, snap_pos_d, idx_q, idx_d;
  scan_state_t       state_q, state_d;
  logic [CW-1:0]     scan_cnt_up_q, scan_cnt_up_d, scan_cnt_dn_q, scan_cnt_dn_d;
  logic [FW-1:0]     scan_near_up_q, scan_near_up_d, scan_near_dn_q, scan_near_dn_d;
  logic              scan_found_up_q, scan_found_up_d, scan_found_dn_q, scan_found_dn_d;
  logic [CW-1:0]     count_up_q, count_up_d, count_down_q, count_down_d;
  logic [FW-1:0]     nearest_up_q, nearest_up_d, nearest_down_q, nearest_down_d;
  logic              up_found_q, up_found_d, down_found_q, down_found_d;
  logic              summary_valid_q, summary_valid_d;

  call_button_filter #(.N(FLOORS), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt_up (
    .clock(clock), .reset(reset), .btn_in(hall_up_btn), .press_pulse(up_pulse_s));
  call_button_filter #(.N(FLOORS), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt_dn (
    .clock(clock), .reset(reset), .btn_in(hall_dn_btn), .press_pulse(dn_pulse_s));
  call_button_filter #(.N(FLOORS), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt_car (
    .clock(clock), .reset(reset), .btn_in(car_btn), .press_pulse(car_pulse_s));

  // Serve decode; out-of-range floors still acknowledge but clear nothing.
  always_comb begin
    clr_up_s    = '0;
    clr_dn_s    = '0;
    clr_dest_s  = '0;
    serve_ack_d = serve_valid;
    if (serve_valid && (32'(serve_floor) < FLOORS)) begin
      clr_dest_s[serve_floor] = 1'b1;
      clr_up_s[serve_floor]   = (serve_dir == DIR_UP);
      clr_dn_s[serve_floor]   = (serve_dir == DIR_DOWN);
    end else begin
      clr_dest_s = '0;
    end
  end

  // Request vectors: clear beats set, off discards everything including new presses.
  always_comb begin
    if (off_btn) begin
      pressed_up_d  = '0;
      pressed_dn_d  = '0;
      destination_d = '0;
    end else begin
      pressed_up_d  = (pressed_up_q  | (up_pulse_s & UP_MASK)) & ~clr_up_s;
      pressed_dn_d  = (pressed_dn_q  | (dn_pulse_s & DN_MASK)) & ~clr_dn_s;
      destination_d = (destination_q | car_pulse_s)            & ~clr_dest_s;
    end
    dirty_set_s = off_btn || (position != position_q) || (pressed_up_d != pressed_up_q)
               || (pressed_dn_d != pressed_dn_q) || (destination_d != destination_q);
  end

  // Scan FSM: snapshot, walk floors 0..FLOORS-1, then publish.
  always_comb begin
    state_d         = state_q;
    dirty_clr_s     = 1'b0;
    snap_pos_d      = snap_pos_q;
    snap_req_d      = snap_req_q;
    idx_d           = idx_q;
    scan_cnt_up_d   = scan_cnt_up_q;
    scan_cnt_dn_d   = scan_cnt_dn_q;
    scan_near_up_d  = scan_near_up_q;
    scan_near_dn_d  = scan_near_dn_q;
    scan_found_up_d = scan_found_up_q;
    scan_found_dn_d = scan_found_dn_q;
    count_up_d      = count_up_q;
    count_down_d    = count_down_q;
    nearest_up_d    = nearest_up_q;
    nearest_down_d  = nearest_down_q;
    up_found_d      = up_found_q;
    down_found_d    = down_found_q;
    summary_valid_d = summary_valid_q;
    case (state_q)
      S_IDLE: begin
        if (dirty_q) begin
          snap_pos_d      = position;
          snap_req_d      = pressed_up_q | pressed_dn_q | destination_q;
          dirty_clr_s     = 1'b1;
          idx_d           = '0;
          summary_valid_d = 1'b0;
          scan_cnt_up_d   = '0;
          scan_cnt_dn_d   = '0;
          scan_near_up_d  = position;
          scan_near_dn_d  = position;
          scan_found_up_d = 1'b0;
          scan_found_dn_d = 1'b0;
          state_d         = S_SCAN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        if (snap_req_q[idx_q] && (idx_q > snap_pos_q)) begin
          scan_cnt_up_d = scan_cnt_up_q + CW'(1);
          if (!scan_found_up_q) begin
            scan_near_up_d  = idx_q;
            scan_found_up_d = 1'b1;
          end else begin
            scan_near_up_d = scan_near_up_q;
          end
        end else if (snap_req_q[idx_q] && (idx_q < snap_pos_q)) begin
          scan_cnt_dn_d   = scan_cnt_dn_q + CW'(1);
          scan_near_dn_d  = idx_q;
          scan_found_dn_d = 1'b1;
        end else begin
          scan_cnt_up_d = scan_cnt_up_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + FW'(1);
        end
      end
      S_DONE: begin
        count_up_d      = scan_cnt_up_q;
        count_down_d    = scan_cnt_dn_q;
        nearest_up_d    = scan_near_up_q;
        nearest_down_d  = scan_near_dn_q;
        up_found_d      = scan_found_up_q;
        down_found_d    = scan_found_dn_q;
        summary_valid_d = 1'b1;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A change during the snapshot cycle must survive the clear.
    dirty_d = dirty_set_s | (dirty_q & ~dirty_clr_s);
  end

  // State registers; reset leaves dirty set so the first scan publishes zeros.
  always_ff @(posedge clock) begin
    if (reset) begin
      pressed_up_q <= '0;  pressed_dn_q <= '0;  destination_q <= '0;
      serve_ack_q <= 1'b0; dirty_q <= 1'b1;     position_q <= '0;
      state_q <= S_IDLE;   snap_pos_q <= '0;    snap_req_q <= '0;  idx_q <= '0;
      scan_cnt_up_q <= '0; scan_cnt_dn_q <= '0; scan_near_up_q <= '0; scan_near_dn_q <= '0;
      scan_found_up_q <= 1'b0; scan_found_dn_q <= 1'b0;
      count_up_q <= '0;    count_down_q <= '0;  nearest_up_q <= '0; nearest_down_q <= '0;
      up_found_q <= 1'b0;  down_found_q <= 1'b0; summary_valid_q <= 1'b0;
    end else begin
      pressed_up_q <= pressed_up_d; pressed_dn_q <= pressed_dn_d; destination_q <= destination_d;
      serve_ack_q <= serve_ack_d;   dirty_q <= dirty_d;          position_q <= position;
      state_q <= state_d; snap_pos_q <= snap_pos_d; snap_req_q <= snap_req_d; idx_q <= idx_d;
      scan_cnt_up_q <= scan_cnt_up_d;   scan_cnt_dn_q <= scan_cnt_dn_d;
      scan_near_up_q <= scan_near_up_d; scan_near_dn_q <= scan_near_dn_d;
      scan_found_up_q <= scan_found_up_d; scan_found_dn_q <= scan_found_dn_d;
      count_up_q <= count_up_d;     count_down_q <= count_down_d;
      nearest_up_q <= nearest_up_d; nearest_down_q <= nearest_down_d;
      up_found_q <= up_found_d;     down_found_q <= down_found_d;
      summary_valid_q <= summary_valid_d;
    end
  end

  assign serve_ack     = serve_ack_q;
  assign pressed_up    = pressed_up_q;
  assign pressed_dn    = pressed_dn_q;
  assign destination   = destination_q;
  assign count_up      = count_up_q;
  assign count_down    = count_down_q;
  assign nearest_up    = nearest_up_q;
  assign nearest_down  = nearest_down_q;
  assign up_found      = up_found_q;
  assign down_found    = down_found_q;
  assign summary_valid = summary_valid_q;

endmodule

// File: tb/tb_elevator_call_register.sv
// Directed bench for elevator_call_register (FLOORS=10, debounce disabled).
module tb_elevator_call_register;

  logic       clock = 1'b0;
  logic       reset, off_btn, serve_valid, serve_dir;
  logic [3:0] position, serve_floor;
  logic [9:0] hall_up_btn, hall_dn_btn, car_btn;
  logic       serve_ack, up_found, down_found, summary_valid;
  logic [9:0] pressed_up, pressed_dn, destination;
  logic [3:0] count_up, count_down, nearest_up, nearest_down;
  int         checks, errors, n;

  always #5 clock = ~clock;

  elevator_call_register dut (
    .clock(clock), .reset(reset), .off_btn(off_btn), .position(position),
    .hall_up_btn(hall_up_btn), .hall_dn_btn(hall_dn_btn), .car_btn(car_btn),
    .serve_valid(serve_valid), .serve_floor(serve_floor), .serve_dir(serve_dir),
    .serve_ack(serve_ack), .pressed_up(pressed_up), .pressed_dn(pressed_dn),
    .destination(destination), .count_up(count_up), .count_down(count_down),
    .nearest_up(nearest_up), .nearest_down(nearest_down), .up_found(up_found),
    .down_found(down_found), .summary_valid(summary_valid));

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_summary(input string tag, input int cu, input int nu, input int fu,
                             input int cd, input int nd, input int fd);
    chk({tag, "_count_up"}, count_up, cu);
    chk({tag, "_nearest_up"}, nearest_up, nu);
    chk({tag, "_up_found"}, up_found, fu);
    chk({tag, "_count_down"}, count_down, cd);
    chk({tag, "_nearest_down"}, nearest_down, nd);
    chk({tag, "_down_found"}, down_found, fd);
  endtask

  // Steps until summary_valid is seen or the budget runs out.
  task automatic wait_valid(input string tag, input int budget, output int cnt);
    cnt = 0;
    while (cnt < budget) begin
      step();
      cnt++;
      if (summary_valid === 1'b1) break;
    end
    chk({tag, "_valid_seen"}, summary_valid, 1);
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; off_btn = 1'b0; position = 4'd0; serve_valid = 1'b0;
    serve_floor = 4'd0; serve_dir = 1'b0;
    hall_up_btn = 10'd0; hall_dn_btn = 10'd0; car_btn = 10'd0;
    repeat (3) step();
    chk("rst_valid", summary_valid, 0);
    chk("rst_ack", serve_ack, 0);
    chk("rst_up", pressed_up, 0);
    chk("rst_dn", pressed_dn, 0);
    chk("rst_dest", destination, 0);
    chk_summary("rst", 0, 0, 0, 0, 0, 0);

    // 1: first publish 12 cycles after reset release
    reset = 1'b0;
    wait_valid("t1", 40, n);
    chk("t1_latency", n, 12);
    chk_summary("t1", 0, 0, 0, 0, 0, 0);

    // 2: position 4, up call at 7, car call at 2
    position = 4'd4; hall_up_btn[7] = 1'b1; car_btn[2] = 1'b1;
    step();
    chk("t2_up", pressed_up, 10'h080);
    chk("t2_dest", destination, 10'h004);
    hall_up_btn = 10'd0; car_btn = 10'd0;
    wait_valid("t2", 40, n);
    chk("t2_latency", n, 12);
    chk_summary("t2", 1, 7, 1, 1, 2, 1);

    // 3: serve floor 7 upward
    serve_valid = 1'b1; serve_floor = 4'd7; serve_dir = 1'b1;
    step();
    chk("t3_ack", serve_ack, 1);
    chk("t3_up", pressed_up, 0);
    chk("t3_dest", destination, 10'h004);
    serve_valid = 1'b0;
    step();
    chk("t3_ack_drop", serve_ack, 0);
    wait_valid("t3", 40, n);
    chk("t3_latency", n, 11);
    chk_summary("t3", 0, 4, 0, 1, 2, 1);

    // 4: press and serve of floor 5 together, then an out-of-range serve
    car_btn[5] = 1'b1; serve_valid = 1'b1; serve_floor = 4'd5; serve_dir = 1'b0;
    step();
    chk("t4_dest", destination, 10'h004);
    chk("t4_ack", serve_ack, 1);
    car_btn = 10'd0; serve_floor = 4'd12;
    step();
    chk("t4_oor_ack", serve_ack, 1);
    chk("t4_oor_dest", destination, 10'h004);
    serve_valid = 1'b0;
    step();
    chk("t4_ack_drop", serve_ack, 0);
    chk("t4_no_rescan", summary_valid, 1);

    // 5: requests at 1, 3, 8 then off with a simultaneous press
    hall_up_btn[1] = 1'b1; hall_dn_btn[3] = 1'b1; car_btn[8] = 1'b1;
    step();
    chk("t5_up", pressed_up, 10'h002);
    chk("t5_dn", pressed_dn, 10'h008);
    chk("t5_dest", destination, 10'h104);
    hall_up_btn = 10'd0; hall_dn_btn = 10'd0; car_btn = 10'd0;
    step();
    off_btn = 1'b1; car_btn[6] = 1'b1;
    step();
    chk("t5_off_up", pressed_up, 0);
    chk("t5_off_dn", pressed_dn, 0);
    chk("t5_off_dest", destination, 0);
    off_btn = 1'b0;
    step();
    chk("t5_held", destination, 0);
    car_btn = 10'd0;
    wait_valid("t5a", 40, n);
    chk_summary("t5a", 1, 8, 1, 3, 3, 1);
    wait_valid("t5b", 40, n);
    chk_summary("t5b", 0, 4, 0, 0, 4, 0);
    hall_dn_btn[0] = 1'b1; hall_up_btn[9] = 1'b1;
    step();
    chk("t5_ign_up", pressed_up, 0);
    chk("t5_ign_dn", pressed_dn, 0);
    hall_dn_btn = 10'd0; hall_up_btn = 10'd0;
    repeat (2) step();
    chk("t5_ign_valid", summary_valid, 1);

    // 6: position 4 -> 5 during a scan
    car_btn[5] = 1'b1; car_btn[7] = 1'b1; hall_dn_btn[3] = 1'b1;
    step();
    car_btn = 10'd0; hall_dn_btn = 10'd0;
    repeat (4) step();
    position = 4'd5;
    step();
    wait_valid("t6a", 40, n);
    chk_summary("t6a", 2, 5, 1, 1, 3, 1);
    step();
    chk("t6_drop", summary_valid, 0);
    wait_valid("t6b", 40, n);
    chk("t6_gap", n, 11);
    chk_summary("t6b", 1, 7, 1, 1, 3, 1);

    // 7: reset in the middle of a scan
    position = 4'd6;
    repeat (4) step();
    reset = 1'b1;
    step();
    chk("t7_valid", summary_valid, 0);
    chk("t7_dest", destination, 0);
    chk("t7_dn", pressed_dn, 0);
    reset = 1'b0;
    wait_valid("t7", 40, n);
    chk("t7_latency", n, 12);
    chk_summary("t7", 0, 6, 0, 0, 6, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
